// File: rtl/mini_core_pkg.sv
// Shared types for the mini core pipeline: write-back control bundle and its
// enumerations, plus the write-back stage state encoding.
package mini_core_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } t_wb_sel;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } t_ld_size;

  typedef struct packed {
    logic       ValidQ103H;
    logic       RegWrEnQ103H;
    logic [4:0] RegDstQ103H;
    t_wb_sel    WbSelQ103H;
    t_ld_size   LdSizeQ103H;
    logic       LdSignExtQ103H;
  } t_ctrl_wb;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_RSP = 1'b1
  } t_wb_state;

  function automatic logic rf_write_allowed(input logic valid, input logic wr_en,
                                            input logic [4:0] dst);
    return valid & wr_en & (dst != 5'd0);
  endfunction

endpackage

// File: rtl/mini_core_ld_align.sv
// Load data alignment: picks the addressed byte/half out of a word-aligned
// read and sign- or zero-extends it to 32 bits. Purely combinational.
module mini_core_ld_align
  import mini_core_pkg::*;
(
  input  logic [31:0] raw_data,
  input  logic [1:0]  lsb,
  input  t_ld_size    ld_size,
  input  logic        sign_ext,
  output logic [31:0] aligned
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_data[7:0];
    case (lsb)
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      2'd3:    byte_sel = raw_data[31:24];
      default: byte_sel = raw_data[7:0];
    endcase
    // lsb[0] is not looked at for halves: misaligned halves never reach here
    half_sel = lsb[1] ? raw_data[31:16] : raw_data[15:0];

    case (ld_size)
      LD_B:    aligned = ext_byte(byte_sel, sign_ext);
      LD_H:    aligned = ext_half(half_sel, sign_ext);
      default: aligned = raw_data;
    endcase
  end

endmodule

// File: rtl/mini_core_wb.sv
// Write-back stage (Q104H): holds the retiring instruction, selects the
// register file write data and stalls upstream while a load is outstanding.
module mini_core_wb
  import mini_core_pkg::*;
#(
  parameter int RSP_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic        Clock,
  input  logic        Rst,
  input  t_ctrl_wb    Ctrl,
  input  logic [31:0] AluOutQ103H,
  input  logic [31:0] PcPlus4Q103H,
  input  logic        DMemRspValidQ104H,
  input  logic [31:0] DMemRdDataQ104H,
  output logic        ReadyQ104H,
  output logic        RegWrEnQ104H,
  output logic [4:0]  RegDstQ104H,
  output logic [31:0] RegWrDataQ104H,
  output logic        LdTimeoutErr
);

  t_wb_state          state_q, state_d;
  logic               valid_q, valid_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               err_q, err_d;

  logic               reg_wr_en_q, reg_wr_en_d;
  logic [4:0]         reg_dst_q, reg_dst_d;
  t_wb_sel            wb_sel_q, wb_sel_d;
  t_ld_size           ld_size_q, ld_size_d;
  logic               ld_sign_ext_q, ld_sign_ext_d;
  logic [31:0]        alu_out_q, alu_out_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;

  logic               ready;
  logic               wr_req;
  logic               wr_ok;
  logic               is_ld;
  logic [31:0]        ld_data;
  logic [31:0]        wb_data;

  mini_core_ld_align u_ld_align (
    .raw_data (DMemRdDataQ104H),
    .lsb      (alu_out_q[1:0]),
    .ld_size  (ld_size_q),
    .sign_ext (ld_sign_ext_q),
    .aligned  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    ready   = 1'b1;
    wr_req  = 1'b0;
    wr_ok   = rf_write_allowed(valid_q, reg_wr_en_q, reg_dst_q);
    is_ld   = valid_q & (wb_sel_q == WB_MEM);

    case (state_q)
      WB_IDLE: begin
        if (!is_ld || DMemRspValidQ104H) begin
          wr_req = wr_ok;
        end else begin
          ready   = 1'b0;
          state_d = WB_WAIT_RSP;
          timer_d = TMR_W'(1);
        end
      end
      WB_WAIT_RSP: begin
        if (DMemRspValidQ104H) begin
          wr_req  = wr_ok;
          state_d = WB_IDLE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(RSP_TIMEOUT)) begin
          // abandon the load: drop the write but let the pipeline move on
          err_d   = 1'b1;
          state_d = WB_IDLE;
          timer_d = '0;
        end else begin
          ready   = 1'b0;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = WB_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    valid_d       = valid_q;
    reg_wr_en_d   = reg_wr_en_q;
    reg_dst_d     = reg_dst_q;
    wb_sel_d      = wb_sel_q;
    ld_size_d     = ld_size_q;
    ld_sign_ext_d = ld_sign_ext_q;
    alu_out_d     = alu_out_q;
    pc_plus4_d    = pc_plus4_q;
    if (ready) begin
      valid_d       = Ctrl.ValidQ103H;
      reg_wr_en_d   = Ctrl.RegWrEnQ103H;
      reg_dst_d     = Ctrl.RegDstQ103H;
      wb_sel_d      = Ctrl.WbSelQ103H;
      ld_size_d     = Ctrl.LdSizeQ103H;
      ld_sign_ext_d = Ctrl.LdSignExtQ103H;
      alu_out_d     = AluOutQ103H;
      pc_plus4_d    = PcPlus4Q103H;
    end
  end

  always_comb begin
    case (wb_sel_q)
      WB_MEM:  wb_data = ld_data;
      WB_PC4:  wb_data = pc_plus4_q;
      default: wb_data = alu_out_q;
    endcase
  end

  // Q103H -> Q104H boundary
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q <= WB_IDLE;
      valid_q <= 1'b0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clock) begin
    reg_wr_en_q   <= reg_wr_en_d;
    reg_dst_q     <= reg_dst_d;
    wb_sel_q      <= wb_sel_d;
    ld_size_q     <= ld_size_d;
    ld_sign_ext_q <= ld_sign_ext_d;
    alu_out_q     <= alu_out_d;
    pc_plus4_q    <= pc_plus4_d;
  end

  assign ReadyQ104H     = ready;
  assign RegWrEnQ104H   = wr_req;
  assign RegDstQ104H    = wr_req ? reg_dst_q : 5'd0;
  assign RegWrDataQ104H = wr_req ? wb_data : 32'd0;
  assign LdTimeoutErr   = err_q;

endmodule

// File: tb/tb_mini_core_wb.sv
// Bench for the write-back stage: directed vector table, multi-cycle
// sequences (late load, timeout, reset mid-wait) and randomized transactions.
module tb_mini_core_wb;
  import mini_core_pkg::*;

  localparam int T = 4;

  logic        Clock = 1'b0;
  logic        Rst;
  t_ctrl_wb    Ctrl;
  logic [31:0] AluOutQ103H, PcPlus4Q103H, DMemRdDataQ104H;
  logic        DMemRspValidQ104H;
  logic        ReadyQ104H, RegWrEnQ104H, LdTimeoutErr;
  logic [4:0]  RegDstQ104H;
  logic [31:0] RegWrDataQ104H;

  mini_core_wb #(.RSP_TIMEOUT(T), .TMR_W(5)) dut (
    .Clock             (Clock),
    .Rst               (Rst),
    .Ctrl              (Ctrl),
    .AluOutQ103H       (AluOutQ103H),
    .PcPlus4Q103H      (PcPlus4Q103H),
    .DMemRspValidQ104H (DMemRspValidQ104H),
    .DMemRdDataQ104H   (DMemRdDataQ104H),
    .ReadyQ104H        (ReadyQ104H),
    .RegWrEnQ104H      (RegWrEnQ104H),
    .RegDstQ104H       (RegDstQ104H),
    .RegWrDataQ104H    (RegWrDataQ104H),
    .LdTimeoutErr      (LdTimeoutErr)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic sample();
    @(negedge Clock);
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] dst, input t_wb_sel sel,
                       input t_ld_size sz, input logic sx, input logic [31:0] alu,
                       input logic [31:0] pc);
    Ctrl.ValidQ103H     = v;
    Ctrl.RegWrEnQ103H   = we;
    Ctrl.RegDstQ103H    = dst;
    Ctrl.WbSelQ103H     = sel;
    Ctrl.LdSizeQ103H    = sz;
    Ctrl.LdSignExtQ103H = sx;
    AluOutQ103H         = alu;
    PcPlus4Q103H        = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, WB_ALU, LD_W, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rsp(input logic v, input logic [31:0] d);
    DMemRspValidQ104H = v;
    DMemRdDataQ104H   = d;
  endtask

  // Reference load extraction: shift the addressed unit down, mask, then
  // subtract 2^w for negative values when sign-extending.
  function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] lsb,
                                           input t_ld_size sz, input logic sx);
    logic [31:0] sh;
    int          w;
    if (sz == LD_B) begin
      sh = raw >> (8 * int'(lsb));
      w  = 8;
    end else if (sz == LD_H) begin
      sh = raw >> (16 * int'(lsb[1]));
      w  = 16;
    end else begin
      return raw;
    end
    sh = sh & ((32'd1 << w) - 32'd1);
    if (sx && sh[w-1]) sh = sh - (32'd1 << w);
    return sh;
  endfunction

  typedef struct {
    logic        v, we;
    logic [4:0]  dst;
    t_wb_sel     sel;
    t_ld_size    sz;
    logic        sx;
    logic [31:0] alu, pc;
    logic        rv;
    logic [31:0] raw;
    logic        e_we;
    logic [4:0]  e_dst;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        err_exp;
    logic        v, we, sx, rv, exp_we;
    logic [4:0]  dst;
    t_wb_sel     sel;
    t_ld_size    sz;
    logic [31:0] alu, pc, raw;
    int          lat, last;

    Rst = 1'b1;
    bubble();
    rsp(1'b0, 32'd0);
    tick();
    tick();
    sample();
    chk("reset_ready", {31'd0, ReadyQ104H}, 32'd1);
    chk("reset_we",    {31'd0, RegWrEnQ104H}, 32'd0);
    chk("reset_dst",   {27'd0, RegDstQ104H}, 32'd0);
    chk("reset_data",  RegWrDataQ104H, 32'd0);
    chk("reset_err",   {31'd0, LdTimeoutErr}, 32'd0);
    tick();
    Rst = 1'b0;

    tbl.push_back('{1, 1, 5,  WB_ALU, LD_W, 0, 32'h0000_0123, 32'h0, 0, 32'h0,         1, 5,  32'h0000_0123});
    tbl.push_back('{1, 1, 3,  WB_MEM, LD_B, 1, 32'h0000_1002, 32'h0, 1, 32'h0080_0000, 1, 3,  32'hFFFF_FF80});
    tbl.push_back('{1, 1, 3,  WB_MEM, LD_B, 0, 32'h0000_1002, 32'h0, 1, 32'h0080_0000, 1, 3,  32'h0000_0080});
    tbl.push_back('{1, 1, 4,  WB_MEM, LD_H, 1, 32'h0000_2002, 32'h0, 1, 32'h8001_0000, 1, 4,  32'hFFFF_8001});
    tbl.push_back('{1, 1, 0,  WB_ALU, LD_W, 0, 32'h0000_0077, 32'h0, 0, 32'h0,         0, 0,  32'h0});
    tbl.push_back('{0, 1, 6,  WB_ALU, LD_W, 0, 32'h0000_0099, 32'h0, 0, 32'h0,         0, 0,  32'h0});
    tbl.push_back('{0, 1, 6,  WB_ALU, LD_W, 0, 32'h0000_0099, 32'h0, 1, 32'h1234_5678, 0, 0,  32'h0});
    tbl.push_back('{1, 1, 8,  WB_ALU, LD_W, 0, 32'h0000_00AA, 32'h0, 1, 32'h1234_5678, 1, 8,  32'h0000_00AA});
    tbl.push_back('{1, 1, 1,  WB_PC4, LD_W, 0, 32'h0000_5555, 32'h104, 0, 32'h0,       1, 1,  32'h0000_0104});
    tbl.push_back('{1, 1, 10, WB_MEM, LD_H, 0, 32'h0000_0300, 32'h0, 1, 32'h1234_F00D, 1, 10, 32'h0000_F00D});
    tbl.push_back('{1, 1, 11, WB_MEM, LD_H, 1, 32'h0000_0303, 32'h0, 1, 32'h9ABC_0000, 1, 11, 32'hFFFF_9ABC});
    tbl.push_back('{1, 1, 12, WB_MEM, LD_B, 1, 32'h0000_0401, 32'h0, 1, 32'h0000_7F00, 1, 12, 32'h0000_007F});
    tbl.push_back('{1, 1, 13, WB_MEM, LD_B, 0, 32'h0000_0403, 32'h0, 1, 32'hC300_0000, 1, 13, 32'h0000_00C3});
    tbl.push_back('{1, 1, 31, WB_MEM, LD_W, 1, 32'h0000_0500, 32'h0, 1, 32'hCAFE_BABE, 1, 31, 32'hCAFE_BABE});
    tbl.push_back('{1, 0, 14, WB_MEM, LD_W, 0, 32'h0000_0600, 32'h0, 1, 32'h1111_1111, 0, 0,  32'h0});
    tbl.push_back('{1, 1, 0,  WB_MEM, LD_W, 0, 32'h0000_0700, 32'h0, 1, 32'h2222_2222, 0, 0,  32'h0});

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].dst, tbl[i].sel, tbl[i].sz, tbl[i].sx, tbl[i].alu, tbl[i].pc);
      rsp(1'b0, 32'd0);
      tick();
      bubble();
      rsp(tbl[i].rv, tbl[i].raw);
      sample();
      chk($sformatf("vec%0d_ready", i), {31'd0, ReadyQ104H}, 32'd1);
      chk($sformatf("vec%0d_we", i), {31'd0, RegWrEnQ104H}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_dst", i), {27'd0, RegDstQ104H}, {27'd0, tbl[i].e_dst});
        chk($sformatf("vec%0d_data", i), RegWrDataQ104H, tbl[i].e_data);
      end
      tick();
    end

    // late load response with an ADD waiting behind it
    drive(1, 1, 5'd7, WB_MEM, LD_W, 0, 32'h0000_0800, 32'h0);
    rsp(1'b0, 32'd0);
    tick();
    drive(1, 1, 5'd9, WB_ALU, LD_W, 0, 32'h0000_0055, 32'h0);
    for (int k = 0; k < 3; k++) begin
      rsp(1'b0, 32'h5A5A_5A5A);
      sample();
      chk($sformatf("late_stall%0d_ready", k), {31'd0, ReadyQ104H}, 32'd0);
      chk($sformatf("late_stall%0d_we", k), {31'd0, RegWrEnQ104H}, 32'd0);
      tick();
    end
    rsp(1'b1, 32'hDEAD_BEEF);
    sample();
    chk("late_done_ready", {31'd0, ReadyQ104H}, 32'd1);
    chk("late_done_we",    {31'd0, RegWrEnQ104H}, 32'd1);
    chk("late_done_dst",   {27'd0, RegDstQ104H}, 32'd7);
    chk("late_done_data",  RegWrDataQ104H, 32'hDEAD_BEEF);
    tick();
    bubble();
    rsp(1'b0, 32'd0);
    sample();
    chk("late_add_we",   {31'd0, RegWrEnQ104H}, 32'd1);
    chk("late_add_dst",  {27'd0, RegDstQ104H}, 32'd9);
    chk("late_add_data", RegWrDataQ104H, 32'h0000_0055);
    tick();
    sample();
    chk("late_after_we", {31'd0, RegWrEnQ104H}, 32'd0);
    tick();

    // no response at all: timeout
    drive(1, 1, 5'd3, WB_MEM, LD_W, 0, 32'h0000_0900, 32'h0);
    tick();
    bubble();
    for (int k = 0; k < T; k++) begin
      sample();
      chk($sformatf("tmo_stall%0d_ready", k), {31'd0, ReadyQ104H}, 32'd0);
      chk($sformatf("tmo_stall%0d_we", k), {31'd0, RegWrEnQ104H}, 32'd0);
      tick();
    end
    sample();
    chk("tmo_release_ready", {31'd0, ReadyQ104H}, 32'd1);
    chk("tmo_release_we",    {31'd0, RegWrEnQ104H}, 32'd0);
    tick();
    sample();
    chk("tmo_err_set", {31'd0, LdTimeoutErr}, 32'd1);
    drive(1, 1, 5'd2, WB_ALU, LD_W, 0, 32'h0000_0042, 32'h0);
    tick();
    bubble();
    rsp(1'b1, 32'hFFFF_FFFF);
    sample();
    chk("tmo_resume_data", RegWrDataQ104H, 32'h0000_0042);
    chk("tmo_err_sticky",  {31'd0, LdTimeoutErr}, 32'd1);
    tick();
    rsp(1'b0, 32'd0);

    // reset while waiting, then a response that must be ignored
    drive(1, 1, 5'd4, WB_MEM, LD_W, 0, 32'h0000_0A00, 32'h0);
    tick();
    bubble();
    sample();
    chk("rstw_stall_ready", {31'd0, ReadyQ104H}, 32'd0);
    tick();
    Rst = 1'b1;
    sample();
    chk("rstw_wait_ready", {31'd0, ReadyQ104H}, 32'd0);
    tick();
    Rst = 1'b0;
    rsp(1'b1, 32'h1111_2222);
    sample();
    chk("rstw_we",    {31'd0, RegWrEnQ104H}, 32'd0);
    chk("rstw_ready", {31'd0, ReadyQ104H}, 32'd1);
    chk("rstw_err",   {31'd0, LdTimeoutErr}, 32'd0);
    tick();
    rsp(1'b0, 32'd0);

    // randomized transactions against the reference model
    err_exp = 1'b0;
    for (int n = 0; n < 200; n++) begin
      v   = ($urandom_range(0, 7) != 0);
      we  = 1'($urandom_range(0, 1));
      dst = 5'($urandom_range(0, 31));
      sel = t_wb_sel'($urandom_range(0, 2));
      sz  = t_ld_size'($urandom_range(0, 2));
      sx  = 1'($urandom_range(0, 1));
      alu = $urandom;
      pc  = $urandom;
      raw = $urandom;
      exp_we = v && we && (dst != 5'd0);
      drive(v, we, dst, sel, sz, sx, alu, pc);
      rsp(1'b0, $urandom);
      tick();
      bubble();
      if (v && sel == WB_MEM) begin
        lat  = ($urandom_range(0, 7) == 0) ? T + 1 : int'($urandom_range(0, T));
        last = (lat <= T) ? lat : T;
        for (int k = 0; k <= last; k++) begin
          rsp(k == lat, (k == lat) ? raw : $urandom);
          sample();
          chk($sformatf("rnd%0d_err", n), {31'd0, LdTimeoutErr}, {31'd0, err_exp});
          if (k < last) begin
            chk($sformatf("rnd%0d_c%0d_ready", n, k), {31'd0, ReadyQ104H}, 32'd0);
            chk($sformatf("rnd%0d_c%0d_we", n, k), {31'd0, RegWrEnQ104H}, 32'd0);
          end else begin
            chk($sformatf("rnd%0d_end_ready", n), {31'd0, ReadyQ104H}, 32'd1);
            chk($sformatf("rnd%0d_end_we", n), {31'd0, RegWrEnQ104H},
                {31'd0, (lat <= T) && exp_we});
            if ((lat <= T) && exp_we) begin
              chk($sformatf("rnd%0d_ld_dst", n), {27'd0, RegDstQ104H}, {27'd0, dst});
              chk($sformatf("rnd%0d_ld_data", n), RegWrDataQ104H, ref_load(raw, alu[1:0], sz, sx));
            end
          end
          tick();
        end
        if (lat > T) err_exp = 1'b1;
      end else begin
        rv = 1'($urandom_range(0, 1));
        rsp(rv, $urandom);
        sample();
        chk($sformatf("rnd%0d_ready", n), {31'd0, ReadyQ104H}, 32'd1);
        chk($sformatf("rnd%0d_we", n), {31'd0, RegWrEnQ104H}, {31'd0, exp_we});
        if (exp_we) begin
          chk($sformatf("rnd%0d_dst", n), {27'd0, RegDstQ104H}, {27'd0, dst});
          chk($sformatf("rnd%0d_data", n), RegWrDataQ104H, (sel == WB_PC4) ? pc : alu);
        end
        tick();
      end
      rsp(1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_core_wb.md
Name: mini_core_wb

Overview:
- Write-back stage (Q104H) of the mini core; the write port driver for the register file, which it feeds with RegWrEnQ104H, RegDstQ104H and RegWrDataQ104H.
- Accepts retiring instructions from Q103H and selects the write-back source: ALU result, PC+4, or load data.
- Aligns and sign- or zero-extends load data.
- Stalls the pipeline while a load response from data memory is outstanding, using variable latency and a timeout.

Parameters:
- RSP_TIMEOUT, 16, maximum number of Q104H cycles to wait for a load response before abandoning it (must be >= 1).
- TMR_W, 5, width of the timeout counter (must satisfy 2^TMR_W > RSP_TIMEOUT).

Ports:
- Clock  in  1  core clock
- Rst  in  1  synchronous, active-high reset
- Ctrl  in  t_ctrl_wb  Q103H control: ValidQ103H, RegWrEnQ103H, RegDstQ103H[4:0], WbSelQ103H (t_wb_sel), LdSizeQ103H (t_ld_size), LdSignExtQ103H
- AluOutQ103H  in  32  ALU result; also the load address (bits [1:0] used for alignment)
- PcPlus4Q103H  in  32  link value for JAL/JALR
- DMemRspValidQ104H  in  1  load read-data valid from data memory
- DMemRdDataQ104H  in  32  raw word-aligned load data
- ReadyQ104H  out  1  1 = stage accepts a Q103H instruction this cycle; 0 stalls Q101H–Q103H
- RegWrEnQ104H  out  1  register file write enable
- RegDstQ104H  out  5  destination register
- RegWrDataQ104H  out  32  write data
- LdTimeoutErr  out  1  sticky flag: a load response timed out

Behaviour:
- The clock is Clock. Reset is synchronous and active-high on Rst.
- Reset values: state=IDLE, Q104H valid=0, timer=0, LdTimeoutErr=0. Consequently ReadyQ104H=1, RegWrEnQ104H=0, RegDstQ104H=0, RegWrDataQ104H=0.
- Capture: on a Clock edge with ReadyQ104H=1, all Q103H inputs are registered into Q104H holding registers.
  - The captured valid bit equals ValidQ103H.
  - With ReadyQ104H=0, the holding registers keep their value.
- State machine with two states, IDLE and WAIT_RSP.
- IDLE, captured instruction is non-load (WbSel=ALU or PC4):
  - RegWrEnQ104H = valid & RegWrEn & (RegDst!=0), in the same cycle the instruction sits in Q104H.
  - Data is AluOut or PcPlus4.
  - ReadyQ104H=1. Latency is 1 cycle from Q103H.
- IDLE, valid load (WbSel=MEM) with DMemRspValidQ104H=1 in that cycle:
  - Write occurs combinationally with aligned data.
  - ReadyQ104H=1. Stays in IDLE.
- IDLE, valid load with DMemRspValidQ104H=0:
  - ReadyQ104H=0, RegWrEnQ104H=0.
  - Next state is WAIT_RSP and timer is set to 1.
- WAIT_RSP:
  - ReadyQ104H=0 and the holding registers are frozen.
  - On DMemRspValidQ104H=1: write the aligned data in that cycle, set ReadyQ104H=1, next state IDLE, timer cleared.
  - On no response with timer==RSP_TIMEOUT: the write is dropped (RegWrEnQ104H=0), LdTimeoutErr is set, ReadyQ104H=1, next state IDLE.
  - Otherwise the timer increments.
- A valid load with RegDst=0 still waits for its response, but the write is suppressed.
- DMemRspValidQ104H is ignored when no load is outstanding.
- LdTimeoutErr clears only on Rst.
- Load alignment, with lsb = AluOut[1:0] of the held instruction:
  - BYTE: selects byte lsb.
  - HALF: selects half lsb[1]; lsb[0] is ignored because misalignment is trapped upstream.
  - WORD: passes the word unchanged.
  - Sign extension when LdSignExt=1, else zero extension.
- Rst during WAIT_RSP: return to IDLE and issue no write.
  - A response arriving in the cycle after reset is ignored.
- Back-to-back: a non-load in Q103H is accepted in the cycle a waiting load completes. It writes in the next cycle, so one write per cycle.

Decomposition:
- mini_core_pkg gains:
  - t_wb_sel enum: WB_ALU, WB_MEM, WB_PC4.
  - t_ld_size enum: LD_B, LD_H, LD_W.
  - t_ctrl_wb struct with the fields listed under Ctrl.
- Sub-module mini_core_ld_align: purely combinational (raw data, lsb, size, sign) -> 32-bit aligned result. It is unit-testable on its own.

Test Plan:
- ALU write: ADD into x5, AluOut=0x0000_0123 -> next cycle RegWrEnQ104H=1, RegDstQ104H=5, RegWrDataQ104H=0x0000_0123, ReadyQ104H=1 throughout.
- Immediate load: LB signed, lsb=2, raw=0x0080_0000, response same cycle -> RegWrDataQ104H=0xFFFF_FF80; with LBU -> 0x0000_0080; LH signed lsb=2, raw=0x8001_0000 -> 0xFFFF_8001.
- Delayed load: LW to x7, response arrives 3 cycles late with 0xDEAD_BEEF -> ReadyQ104H=0 for 3 cycles, no write, then one write of 0xDEAD_BEEF to x7. An ADD queued in Q103H writes in the following cycle.
- Timeout: RSP_TIMEOUT=4, no response -> ReadyQ104H low 4 cycles, no write, LdTimeoutErr=1 and remains 1, pipeline resumes.
- x0 and bubbles: ADD to x0, or ValidQ103H=0 -> RegWrEnQ104H=0. A stray DMemRspValidQ104H while IDLE and non-load -> no write.
- Reset mid-wait: assert Rst during WAIT_RSP, then deliver the response -> no write, ReadyQ104H=1, LdTimeoutErr=0.
